// File: rtl/regfile_dump_if.sv
// Dump beat stream between regfile_dump (master) and its consumer (slave).
// Carries the valid/ready handshake together with the beat index and value.
interface regfile_dump_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5
);
  logic               o_dump_valid;
  logic               i_dump_ready;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;

  modport master (output o_dump_valid, o_dump_addr, o_dump_data, input i_dump_ready);
  modport slave  (input o_dump_valid, o_dump_addr, o_dump_data, output i_dump_ready);
endinterface

// File: rtl/regfile_dump.sv
// Register file with two combinational read ports and a streaming full-register dump.
// Optional same-cycle write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_dump #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr1,
  input  logic [NB_ADDR-1:0] i_rd_addr2,
  output logic [NB_DATA-1:0] o_rd_data1,
  output logic [NB_DATA-1:0] o_rd_data2,
  input  logic               i_dump_start,
  regfile_dump_if.master     dump,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  localparam int unsigned        DEPTH    = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(DEPTH - 1);
  localparam bit                 ZERO_EN  = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_e;

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic               wr_en_c;

  state_e             state_q,  state_d;
  logic [NB_ADDR-1:0] idx_q,    idx_d;
  logic               valid_q,  valid_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [NB_ADDR-1:0] addr_q,   addr_d;
  logic [NB_DATA-1:0] data_q,   data_d;
  logic               load_c;

  assign wr_en_c = i_we && !(ZERO_EN && (i_wr_addr == '0));

  // Storage array; reset clears every entry.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en_c) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  function automatic logic [NB_DATA-1:0] rd_port(input logic [NB_ADDR-1:0] addr);
    logic [NB_DATA-1:0] val;
    val = mem_q[addr];
    if (ZERO_EN && (addr == '0)) val = '0;
`ifdef REGFILE_BYPASS_EN
    else if (i_we && (addr == i_wr_addr)) val = i_wr_data;
`endif
    return val;
  endfunction

  always_comb begin
    o_rd_data1 = rd_port(i_rd_addr1);
    o_rd_data2 = rd_port(i_rd_addr2);
  end

  // Dump state and beat registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Beat loads sample mem_q before this edge's write lands, so a beat carries pre-write contents.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    load_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (i_dump_start) begin
          state_d = S_SEND;
          idx_d   = '0;
          busy_d  = 1'b1;
          load_c  = 1'b1;
        end
      end
      S_SEND: begin
        if (valid_q && dump.i_dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + NB_ADDR'(1);
            load_c = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      valid_d = 1'b1;
      addr_d  = idx_d;
      data_d  = (ZERO_EN && (idx_d == '0)) ? '0 : mem_q[idx_d];
    end
  end

  assign dump.o_dump_valid = valid_q;
  assign dump.o_dump_addr  = addr_q;
  assign dump.o_dump_data  = data_q;
  assign o_dump_busy       = busy_q;
  assign o_dump_done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: vector table, bypass/zero-register corners,
// dump streaming with back-pressure and concurrent writes, and reset mid-dump.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        start;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [32];

  regfile_dump_if #(.NB_DATA(32), .NB_ADDR(5)) dif ();

  regfile_dump #(.NB_DATA(32), .NB_ADDR(5), .ZERO_REG(1)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_we         (we),
    .i_wr_addr    (wa),
    .i_wr_data    (wd),
    .i_rd_addr1   (ra1),
    .i_rd_addr2   (ra2),
    .o_rd_data1   (rd1),
    .o_rd_data2   (rd2),
    .i_dump_start (start),
    .dump         (dif.master),
    .o_dump_busy  (busy),
    .o_dump_done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && (a == wa)) return wd;
`endif
    return ref_mem[a];
  endfunction

  task automatic commit();
    if (we && (wa != 5'd0)) ref_mem[wa] = wd;
  endtask

  task automatic next_cycle();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reads();
    chk("rd_data1", rd1, exp_rd(ra1));
    chk("rd_data2", rd2, exp_rd(ra2));
  endtask

  // mode 0: ready high, no writes; mode 1: random ready and writes; mode 2: stall 5 cycles at beat 10 with write 0xFFFF to reg 10
  task automatic run_dump(input int mode, output int cycles);
    int          exp_idx;
    int          stall;
    int          guard;
    logic [31:0] exp_data;
    logic [31:0] nxt;
    bit          hs;
    bit          stalled;

    start = 1'b1; dif.i_dump_ready = 1'b1; we = 1'b0;
    ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
    @(negedge clk);
    chk("start_valid", 32'(dif.o_dump_valid), 32'd0);
    chk("start_busy", 32'(busy), 32'd0);
    next_cycle();
    start = 1'b0;
    cycles   = 1;
    exp_idx  = 0;
    exp_data = 32'h0;
    stall    = 0;
    guard    = 0;
    nxt      = 32'h0;

    while (exp_idx < 32) begin
      guard++;
      if (guard > 2000) begin
        chk("dump_timeout", 32'(guard), 32'd0);
        break;
      end
      we = 1'b0;
      stalled = (mode == 2) && (exp_idx == 10) && (stall < 5);
      if (mode == 0) dif.i_dump_ready = 1'b1;
      else if (mode == 1) dif.i_dump_ready = ($urandom_range(0, 99) < 60);
      else dif.i_dump_ready = !stalled;
      if (mode == 1 && $urandom_range(0, 1) == 1) begin
        we = 1'b1; wa = 5'($urandom_range(0, 31)); wd = $urandom();
      end
      if (stalled) begin
        if (stall == 0) begin
          we = 1'b1; wa = 5'd10; wd = 32'h0000FFFF;
        end
        stall++;
      end
      start = (exp_idx == 5);
      ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("beat_valid", 32'(dif.o_dump_valid), 32'd1);
      chk("beat_busy", 32'(busy), 32'd1);
      chk("beat_done", 32'(done), 32'd0);
      chk("beat_addr", 32'(dif.o_dump_addr), 32'(exp_idx));
      chk("beat_data", dif.o_dump_data, exp_data);
      if (mode == 2 && exp_idx == 10) chk("stall_beat10_data", dif.o_dump_data, 32'd40);
      chk_reads();
      hs = dif.i_dump_ready;
      if (hs && exp_idx < 31) nxt = ref_mem[5'(exp_idx + 1)];
      next_cycle();
      cycles++;
      if (hs) begin
        exp_idx++;
        exp_data = nxt;
      end
    end

    start = 1'b0; we = 1'b0; dif.i_dump_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", 32'(dif.o_dump_valid), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    next_cycle();
    cycles++;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(dif.o_dump_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;

    vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd7,  5'd2,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hCAFEF00D, 32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h11111111, 5'd31, 5'd0,  32'hCAFEF00D, 32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h11111111, 32'h11111111};

    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd9;
    start = 1'b0; dif.i_dump_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(dif.o_dump_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(dif.o_dump_addr), 32'd0);
    chk("rst_data", dif.o_dump_data, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].r1; ra2 = vecs[i].r2;
      @(negedge clk);
      chk("vec_rd1", rd1, vecs[i].e1);
      chk("vec_rd2", rd2, vecs[i].e2);
      next_cycle();
    end

    // Same-cycle write/read on reg 3 and on the zero register.
    we = 1'b1; wa = 5'd3; wd = 32'h00000005; ra1 = 5'd0; ra2 = 5'd0;
    @(negedge clk);
    next_cycle();
    wd = 32'hA5A5A5A5; ra1 = 5'd3;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rd1", rd1, 32'hA5A5A5A5);
`else
    chk("bypass_rd1", rd1, 32'h00000005);
`endif
    next_cycle();
    we = 1'b1; wa = 5'd0; wd = 32'h0000FFFF; ra1 = 5'd3; ra2 = 5'd0;
    @(negedge clk);
    chk("after_bypass_rd1", rd1, 32'hA5A5A5A5);
    chk("zero_bypass_rd2", rd2, 32'h0);
    next_cycle();

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31)); wd = $urandom();
      ra1 = 5'($urandom_range(0, 31));
      ra2 = (i % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      @(negedge clk);
      chk_reads();
      next_cycle();
    end

    for (int n = 0; n < 32; n++) begin
      we = 1'b1; wa = 5'(n); wd = 32'(4 * n);
      @(negedge clk);
      next_cycle();
    end
    we = 1'b0;

    run_dump(0, cyc);
    chk("dump_cycles", 32'(cyc), 32'd34);

    run_dump(2, cyc);
    ra1 = 5'd10; we = 1'b0;
    @(negedge clk);
    chk("reg10_after_stall", rd1, 32'h0000FFFF);
    next_cycle();

    run_dump(1, cyc);
    run_dump(1, cyc);

    // Reset in the middle of a dump, while beat 15 is presented.
    start = 1'b1; dif.i_dump_ready = 1'b1; we = 1'b0;
    @(negedge clk);
    next_cycle();
    start = 1'b0;
    for (int b = 0; b < 15; b++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pre_rst_addr", 32'(dif.o_dump_addr), 32'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(dif.o_dump_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_addr", 32'(dif.o_dump_addr), 32'd0);
    chk("midrst_data", dif.o_dump_data, 32'd0);
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst_done", 32'(done), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      ra1 = 5'(2 * i); ra2 = 5'(2 * i + 1);
      @(negedge clk);
      chk("postrst_rd1", rd1, 32'h0);
      chk("postrst_rd2", rd2, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, register data width in bits.
REQ-002 The block SHALL have parameter NB_ADDR, default 5, register address width; depth = 2**NB_ADDR entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-004 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_we  input  1  write enable.
REQ-007 The block SHALL have ports i_wr_addr  input  NB_ADDR, and i_wr_data  input  NB_DATA, the write address and data.
REQ-008 The block SHALL have ports i_rd_addr1 and i_rd_addr2  input  NB_ADDR  read addresses.
REQ-009 The block SHALL have ports o_rd_data1 and o_rd_data2  output  NB_DATA  read data.
REQ-010 The block SHALL have port i_dump_start  input  1  request a full-register dump.
REQ-011 The block SHALL have ports o_dump_valid  output  1, and i_dump_ready  input  1, the dump beat handshake.
REQ-012 The block SHALL have ports o_dump_addr  output  NB_ADDR, and o_dump_data  output  NB_DATA, the beat index and value.
REQ-013 The block SHALL have port o_dump_busy  output  1, high from dump accept through DONE.
REQ-014 The block SHALL have port o_dump_done  output  1, a one-cycle pulse when the dump completes.

Function
REQ-015 The block SHALL write i_wr_data to entry i_wr_addr on the rising clk edge when i_we=1; when ZERO_REG=1, writes to address 0 are discarded.
REQ-016 The block SHALL drive read ports combinationally from the array; when ZERO_REG=1, address 0 reads 0.
REQ-017 The dump FSM SHALL have states IDLE, SEND and DONE; on i_dump_start=1 in IDLE it SHALL go to SEND with index 0.
REQ-018 Entering SEND or advancing index, the block SHALL register o_dump_addr=index and o_dump_data=array[index] pre-write contents (0 for index 0 when ZERO_REG=1), with o_dump_valid=1 in the next cycle.
REQ-019 While o_dump_valid=1 and i_dump_ready=0, o_dump_addr and o_dump_data SHALL hold stable, even if the same entry is written meanwhile.
REQ-020 On o_dump_valid and i_dump_ready both 1, the block SHALL increment index and load the next beat with no bubble; after index 2**NB_ADDR-1 it SHALL go to DONE with o_dump_valid=0.
REQ-021 In DONE the block SHALL assert o_dump_done for exactly one cycle and return to IDLE; o_dump_busy SHALL fall in the IDLE cycle.
REQ-022 The block SHALL ignore i_dump_start outside IDLE.
REQ-023 Normal reads and writes SHALL remain fully functional during a dump.
REQ-024 A dump with ready held high SHALL take 2**NB_ADDR beats plus one start cycle and one DONE cycle.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately clear all entries, set the FSM to IDLE, and drive o_dump_valid, o_dump_busy, o_dump_done, o_dump_addr and o_dump_data to 0.
REQ-026 Reset asserted mid-dump SHALL abort the dump with no o_dump_done pulse.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read whose address equals i_wr_addr while i_we=1 SHALL return i_wr_data in the same cycle, except address 0 when ZERO_REG=1.
REQ-028 Without REGFILE_BYPASS_EN, the same read SHALL return the old contents, with the new value visible from the next cycle.

Verification
REQ-029 Write 0xDEADBEEF to reg 7, then read addr1=7 next cycle -> o_rd_data1=0xDEADBEEF.
REQ-030 ZERO_REG=1: write 0x1234 to reg 0, read addr2=0 -> o_rd_data2=0; dump beat 0 data=0.
REQ-031 Bypass: same cycle i_we=1, addr 3, data 0xA5A5A5A5, rd_addr1=3 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value without it.
REQ-032 Load reg n=n*4 for all n, pulse start, ready=1 -> 32 consecutive beats addr 0..31, data 4n for n>0, then done high for one cycle, 34 cycles total.
REQ-033 Dump with ready=0 for 5 cycles at beat 10 while writing 0xFFFF to reg 10 -> beat 10 holds 40 until accepted; a later read of reg 10 returns 0xFFFF.
REQ-034 Assert i_rst_n=0 at beat 15 -> valid, busy and done go 0 immediately, no done pulse, and all registers read 0.
